// File: rtl/data_structures.sv
// Shared types for the rename register file: committed flags and the
// per-register rename entry.
package data_structures;

  localparam int RF_DATA_W    = 64;
  localparam int RF_ROB_IDX_W = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Entry widths track the rename_regfile DATA_W / ROB_IDX_W defaults.
  typedef struct packed {
    logic [RF_DATA_W-1:0]    value;
    logic                    valid;
    logic [RF_ROB_IDX_W-1:0] rob_index;
  } rf_entry_t;

endpackage

// File: rtl/rf_read_port.sv
// One source-operand lookup: immediate, hardwired zero, commit bypass hit,
// then the stored entry (tag returned when the entry is still in flight).
module rf_read_port
  import data_structures::*;
#(
  parameter int GW        = 5,
  parameter int DATA_W    = RF_DATA_W,
  parameter int ROB_IDX_W = RF_ROB_IDX_W,
  parameter int IMM_W     = 16,
  parameter int ZERO_REG  = 31
) (
  input  logic [GW-1:0]        in_idx,
  input  rf_entry_t            in_entry,
  input  logic                 in_use_imm,
  input  logic [IMM_W-1:0]     in_imm,
  input  logic                 in_byp_hit,
  input  logic [DATA_W-1:0]    in_byp_value,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_value,
  output logic [ROB_IDX_W-1:0] out_rob_index
);

  localparam logic [GW-1:0] ZERO_IDX = GW'(ZERO_REG);

  always_comb begin
    out_valid     = 1'b1;
    out_value     = '0;
    out_rob_index = '0;
    if (in_use_imm) begin
      out_value = DATA_W'(in_imm);
    end else if (in_idx == ZERO_IDX) begin
      out_value = '0;
    end else if (in_byp_hit) begin
      out_value = in_byp_value;
    end else if (in_entry.valid) begin
      out_value = in_entry.value;
    end else begin
      out_valid     = 1'b0;
      out_rob_index = in_entry.rob_index;
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Rename register file with a one-deep registered dispatch result.
// Optional same-cycle commit bypass: define RENAME_REGFILE_BYPASS_EN.
module rename_regfile
  import data_structures::*;
#(
  parameter int NUM_GPRS  = 32,
  parameter int DATA_W    = RF_DATA_W,
  parameter int ROB_IDX_W = RF_ROB_IDX_W,
  parameter int IMM_W     = 16,
  parameter int ZERO_REG  = 31,
  localparam int GW       = $clog2(NUM_GPRS)
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_d_valid,
  output logic                 out_d_ready,
  input  logic [GW-1:0]        in_d_src1,
  input  logic [GW-1:0]        in_d_src2,
  input  logic [GW-1:0]        in_d_dst,
  input  logic                 in_d_dst_en,
  input  logic                 in_d_set_nzcv,
  input  logic                 in_d_use_imm,
  input  logic [IMM_W-1:0]     in_d_imm,
  input  logic [ROB_IDX_W-1:0] in_d_rob_index,
  input  logic                 in_c_valid,
  input  logic                 in_c_wr_en,
  input  logic                 in_c_set_nzcv,
  input  logic [GW-1:0]        in_c_reg,
  input  logic [DATA_W-1:0]    in_c_value,
  input  logic [ROB_IDX_W-1:0] in_c_rob_index,
  input  nzcv_t                in_c_nzcv,
  input  logic                 in_flush,
  output logic                 out_valid,
  input  logic                 in_rob_ready,
  output logic                 out_src1_valid,
  output logic [DATA_W-1:0]    out_src1_value,
  output logic [ROB_IDX_W-1:0] out_src1_rob_index,
  output logic                 out_src2_valid,
  output logic [DATA_W-1:0]    out_src2_value,
  output logic [ROB_IDX_W-1:0] out_src2_rob_index,
  output logic                 out_nzcv_valid,
  output nzcv_t                out_nzcv,
  output logic [ROB_IDX_W-1:0] out_nzcv_rob_index
);

  localparam logic [GW-1:0] ZERO_IDX = GW'(ZERO_REG);

  typedef struct packed {
    logic                 s1_vld;
    logic [DATA_W-1:0]    s1_val;
    logic [ROB_IDX_W-1:0] s1_tag;
    logic                 s2_vld;
    logic [DATA_W-1:0]    s2_val;
    logic [ROB_IDX_W-1:0] s2_tag;
    logic                 fl_vld;
    nzcv_t                fl_val;
    logic [ROB_IDX_W-1:0] fl_tag;
  } res_t;

  rf_entry_t            regs_q [NUM_GPRS];
  rf_entry_t            regs_d [NUM_GPRS];
  nzcv_t                nzcv_q, nzcv_d;
  logic                 nzcv_vld_q, nzcv_vld_d;
  logic [ROB_IDX_W-1:0] nzcv_tag_q, nzcv_tag_d;
  logic                 out_valid_q, out_valid_d;
  res_t                 res_q, res_d;

  logic                 accept;
  logic                 c_gpr_wr, c_gpr_hit, c_flag_wr, c_flag_hit;
  logic                 byp1, byp2, byp_f;
  logic                 rd1_vld, rd2_vld, rdf_vld;
  logic [DATA_W-1:0]    rd1_val, rd2_val;
  logic [ROB_IDX_W-1:0] rd1_tag, rd2_tag, rdf_tag;
  nzcv_t                rdf_val;

  assign out_d_ready = !out_valid_q || in_rob_ready;
  assign accept      = in_d_valid && out_d_ready && !in_flush;

  assign c_gpr_wr   = in_c_valid && in_c_wr_en && (in_c_reg != ZERO_IDX);
  assign c_gpr_hit  = c_gpr_wr && (in_c_rob_index == regs_q[in_c_reg].rob_index);
  assign c_flag_wr  = in_c_valid && in_c_set_nzcv;
  assign c_flag_hit = c_flag_wr && (in_c_rob_index == nzcv_tag_q);

`ifdef RENAME_REGFILE_BYPASS_EN
  assign byp1  = c_gpr_hit && (in_c_reg == in_d_src1);
  assign byp2  = c_gpr_hit && (in_c_reg == in_d_src2);
  assign byp_f = c_flag_hit;
`else
  assign byp1  = 1'b0;
  assign byp2  = 1'b0;
  assign byp_f = 1'b0;
`endif

  rf_read_port #(.GW(GW), .DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W),
                 .IMM_W(IMM_W), .ZERO_REG(ZERO_REG)) u_rd1 (
    .in_idx(in_d_src1), .in_entry(regs_q[in_d_src1]), .in_use_imm(1'b0),
    .in_imm(in_d_imm), .in_byp_hit(byp1), .in_byp_value(in_c_value),
    .out_valid(rd1_vld), .out_value(rd1_val), .out_rob_index(rd1_tag)
  );

  rf_read_port #(.GW(GW), .DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W),
                 .IMM_W(IMM_W), .ZERO_REG(ZERO_REG)) u_rd2 (
    .in_idx(in_d_src2), .in_entry(regs_q[in_d_src2]), .in_use_imm(in_d_use_imm),
    .in_imm(in_d_imm), .in_byp_hit(byp2), .in_byp_value(in_c_value),
    .out_valid(rd2_vld), .out_value(rd2_val), .out_rob_index(rd2_tag)
  );

  assign rdf_vld = nzcv_vld_q || byp_f;
  assign rdf_val = byp_f ? in_c_nzcv : (nzcv_vld_q ? nzcv_q : '0);
  assign rdf_tag = rdf_vld ? '0 : nzcv_tag_q;

  // Commit lands first; a flush or a same-cycle rename then overrides valid/tag.
  always_comb begin
    regs_d     = regs_q;
    nzcv_d     = nzcv_q;
    nzcv_vld_d = nzcv_vld_q;
    nzcv_tag_d = nzcv_tag_q;
    if (c_gpr_wr) begin
      regs_d[in_c_reg].value = in_c_value;
      if (c_gpr_hit) regs_d[in_c_reg].valid = 1'b1;
    end
    if (c_flag_wr) begin
      nzcv_d = in_c_nzcv;
      if (c_flag_hit) nzcv_vld_d = 1'b1;
    end
    if (in_flush) begin
      for (int i = 0; i < NUM_GPRS; i++) regs_d[i].valid = 1'b1;
      nzcv_vld_d = 1'b1;
    end else if (accept) begin
      if (in_d_dst_en && (in_d_dst != ZERO_IDX)) begin
        regs_d[in_d_dst].valid     = 1'b0;
        regs_d[in_d_dst].rob_index = in_d_rob_index;
      end
      if (in_d_set_nzcv) begin
        nzcv_vld_d = 1'b0;
        nzcv_tag_d = in_d_rob_index;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (in_flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      res_d = '{s1_vld: rd1_vld, s1_val: rd1_val, s1_tag: rd1_tag,
                s2_vld: rd2_vld, s2_val: rd2_val, s2_tag: rd2_tag,
                fl_vld: rdf_vld, fl_val: rdf_val, fl_tag: rdf_tag};
    end else if (in_rob_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < NUM_GPRS; i++) regs_q[i] <= '{value: '0, valid: 1'b1, rob_index: '0};
      nzcv_q      <= '0;
      nzcv_vld_q  <= 1'b1;
      nzcv_tag_q  <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      regs_q      <= regs_d;
      nzcv_q      <= nzcv_d;
      nzcv_vld_q  <= nzcv_vld_d;
      nzcv_tag_q  <= nzcv_tag_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid          = out_valid_q;
  assign out_src1_valid     = res_q.s1_vld;
  assign out_src1_value     = res_q.s1_val;
  assign out_src1_rob_index = res_q.s1_tag;
  assign out_src2_valid     = res_q.s2_vld;
  assign out_src2_value     = res_q.s2_val;
  assign out_src2_rob_index = res_q.s2_tag;
  assign out_nzcv_valid     = res_q.fl_vld;
  assign out_nzcv           = res_q.fl_val;
  assign out_nzcv_rob_index = res_q.fl_tag;

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed vector table, hand-written corner
// sequences and a randomized run against an array-based reference model.
module tb_rename_regfile;
  import data_structures::*;

  localparam int GW = 5, DW = 64, RW = 4, IW = 16, ZR = 31;
`ifdef RENAME_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  logic          in_rst_n, in_d_valid, out_d_ready;
  logic [GW-1:0] in_d_src1, in_d_src2, in_d_dst, in_c_reg;
  logic          in_d_dst_en, in_d_set_nzcv, in_d_use_imm;
  logic [IW-1:0] in_d_imm;
  logic [RW-1:0] in_d_rob_index, in_c_rob_index;
  logic          in_c_valid, in_c_wr_en, in_c_set_nzcv, in_flush, in_rob_ready;
  logic [DW-1:0] in_c_value;
  nzcv_t         in_c_nzcv, out_nzcv;
  logic          out_valid, out_src1_valid, out_src2_valid, out_nzcv_valid;
  logic [DW-1:0] out_src1_value, out_src2_value;
  logic [RW-1:0] out_src1_rob_index, out_src2_rob_index, out_nzcv_rob_index;

  rename_regfile dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_d_valid(in_d_valid), .out_d_ready(out_d_ready),
    .in_d_src1(in_d_src1), .in_d_src2(in_d_src2), .in_d_dst(in_d_dst),
    .in_d_dst_en(in_d_dst_en), .in_d_set_nzcv(in_d_set_nzcv), .in_d_use_imm(in_d_use_imm),
    .in_d_imm(in_d_imm), .in_d_rob_index(in_d_rob_index),
    .in_c_valid(in_c_valid), .in_c_wr_en(in_c_wr_en), .in_c_set_nzcv(in_c_set_nzcv),
    .in_c_reg(in_c_reg), .in_c_value(in_c_value), .in_c_rob_index(in_c_rob_index),
    .in_c_nzcv(in_c_nzcv), .in_flush(in_flush), .out_valid(out_valid),
    .in_rob_ready(in_rob_ready),
    .out_src1_valid(out_src1_valid), .out_src1_value(out_src1_value),
    .out_src1_rob_index(out_src1_rob_index),
    .out_src2_valid(out_src2_valid), .out_src2_value(out_src2_value),
    .out_src2_rob_index(out_src2_rob_index),
    .out_nzcv_valid(out_nzcv_valid), .out_nzcv(out_nzcv),
    .out_nzcv_rob_index(out_nzcv_rob_index)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: plain arrays of architectural register contents.
  logic [DW-1:0] m_val [32];
  logic          m_vld [32];
  logic [RW-1:0] m_tag [32];
  logic [3:0]    mf_val;
  logic          mf_vld;
  logic [RW-1:0] mf_tag;
  logic          e_valid, e_s1v, e_s2v, e_fv;
  logic [DW-1:0] e_s1d, e_s2d;
  logic [RW-1:0] e_s1t, e_s2t, e_ft;
  logic [3:0]    e_fd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_vld[i] = 1'b1; m_tag[i] = '0;
    end
    mf_val = '0; mf_vld = 1'b1; mf_tag = '0;
    e_valid = 1'b0; e_s1v = 1'b0; e_s2v = 1'b0; e_fv = 1'b0;
    e_s1d = '0; e_s2d = '0; e_s1t = '0; e_s2t = '0; e_ft = '0; e_fd = '0;
  endtask

  function automatic void rd(input logic [4:0] idx, input logic imm_sel, input logic [15:0] imm,
                             output logic v, output logic [63:0] d, output logic [3:0] t);
    v = 1'b1; d = '0; t = '0;
    if (imm_sel) d = {48'h0, imm};
    else if (idx != 5'(ZR)) begin
      if (BYP && in_c_valid && in_c_wr_en && in_c_reg == idx && in_c_rob_index == m_tag[idx])
        d = in_c_value;
      else if (m_vld[idx]) d = m_val[idx];
      else begin v = 1'b0; t = m_tag[idx]; end
    end
  endfunction

  task automatic compare_all();
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("d_ready", 64'(out_d_ready), 64'(!e_valid || in_rob_ready));
    chk("s1_valid", 64'(out_src1_valid), 64'(e_s1v));
    chk("s1_value", out_src1_value, e_s1d);
    chk("s1_tag", 64'(out_src1_rob_index), 64'(e_s1t));
    chk("s2_valid", 64'(out_src2_valid), 64'(e_s2v));
    chk("s2_value", out_src2_value, e_s2d);
    chk("s2_tag", 64'(out_src2_rob_index), 64'(e_s2t));
    chk("nzcv_valid", 64'(out_nzcv_valid), 64'(e_fv));
    chk("nzcv_value", 64'(out_nzcv), 64'(e_fd));
    chk("nzcv_tag", 64'(out_nzcv_rob_index), 64'(e_ft));
  endtask

  // Apply current inputs for one clock, advancing the model by the same rules.
  task automatic step();
    logic ready, acc, v1, v2, fv;
    logic [63:0] d1, d2;
    logic [3:0] t1, t2, ft, fd;
    ready = !e_valid || in_rob_ready;
    acc = in_d_valid && ready && !in_flush;
    rd(in_d_src1, 1'b0, in_d_imm, v1, d1, t1);
    rd(in_d_src2, in_d_use_imm, in_d_imm, v2, d2, t2);
    if (BYP && in_c_valid && in_c_set_nzcv && in_c_rob_index == mf_tag) begin
      fv = 1'b1; fd = in_c_nzcv; ft = '0;
    end else if (mf_vld) begin
      fv = 1'b1; fd = mf_val; ft = '0;
    end else begin
      fv = 1'b0; fd = '0; ft = mf_tag;
    end
    if (in_c_valid && in_c_wr_en && in_c_reg != 5'(ZR)) begin
      m_val[in_c_reg] = in_c_value;
      if (in_c_rob_index == m_tag[in_c_reg]) m_vld[in_c_reg] = 1'b1;
    end
    if (in_c_valid && in_c_set_nzcv) begin
      mf_val = in_c_nzcv;
      if (in_c_rob_index == mf_tag) mf_vld = 1'b1;
    end
    if (in_flush) begin
      for (int i = 0; i < 32; i++) m_vld[i] = 1'b1;
      mf_vld = 1'b1;
      e_valid = 1'b0;
    end else if (acc) begin
      if (in_d_dst_en && in_d_dst != 5'(ZR)) begin
        m_vld[in_d_dst] = 1'b0; m_tag[in_d_dst] = in_d_rob_index;
      end
      if (in_d_set_nzcv) begin mf_vld = 1'b0; mf_tag = in_d_rob_index; end
      e_valid = 1'b1;
      e_s1v = v1; e_s1d = d1; e_s1t = t1;
      e_s2v = v2; e_s2d = d2; e_s2t = t2;
      e_fv = fv; e_fd = fd; e_ft = ft;
    end else if (in_rob_ready) begin
      e_valid = 1'b0;
    end
    @(posedge in_clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    in_d_valid = 0; in_d_src1 = 0; in_d_src2 = 0; in_d_dst = 0; in_d_dst_en = 0;
    in_d_set_nzcv = 0; in_d_use_imm = 0; in_d_imm = 0; in_d_rob_index = 0;
    in_c_valid = 0; in_c_wr_en = 0; in_c_set_nzcv = 0; in_c_reg = 0; in_c_value = 0;
    in_c_rob_index = 0; in_c_nzcv = '0; in_flush = 0; in_rob_ready = 1;
  endtask

  typedef struct {
    logic [4:0]  s1, s2, dst;
    logic        dst_en, use_imm;
    logic [15:0] imm;
    logic [3:0]  tag;
    logic        cv;
    logic [4:0]  creg;
    logic [63:0] cval;
    logic [3:0]  ctag;
    logic        e1v;
    logic [63:0] e1d;
    logic        e2v;
    logic [63:0] e2d;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] s1, s2, dst, input logic dst_en, use_imm,
                              input logic [15:0] imm, input logic [3:0] tag, input logic cv,
                              input logic [4:0] creg, input logic [63:0] cval, input logic [3:0] ctag,
                              input logic e1v, input logic [63:0] e1d,
                              input logic e2v, input logic [63:0] e2d);
    vec_t r;
    r.s1 = s1; r.s2 = s2; r.dst = dst; r.dst_en = dst_en; r.use_imm = use_imm; r.imm = imm;
    r.tag = tag; r.cv = cv; r.creg = creg; r.cval = cval; r.ctag = ctag;
    r.e1v = e1v; r.e1d = e1d; r.e2v = e2v; r.e2d = e2d;
    return r;
  endfunction

  vec_t vt[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Each row is one accepted dispatch; e?d is the value when valid, else the tag.
    vt[0]  = mk(3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 0,     1, 0);
    vt[1]  = mk(5, 6, 5, 1, 0, 0, 2, 0, 0, 0, 0,        1, 0,     1, 0);
    vt[2]  = mk(1, 2, 0, 0, 0, 0, 0, 1, 5, 64'h55, 2,   1, 0,     1, 0);
    vt[3]  = mk(5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 64'h55, 1, 64'h55);
    vt[4]  = mk(0, 0, 5, 1, 0, 0, 2, 0, 0, 0, 0,        1, 0,     1, 0);
    vt[5]  = mk(5, 0, 5, 1, 0, 0, 7, 0, 0, 0, 0,        0, 2,     1, 0);
    vt[6]  = mk(8, 9, 0, 0, 0, 0, 0, 1, 5, 64'h11, 2,   1, 0,     1, 0);
    vt[7]  = mk(5, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 7,     1, 0);
    vt[8]  = mk(31, 5, 0, 0, 1, 16'hABCD, 0, 0, 0, 0, 0, 1, 0,    1, 64'hABCD);
    vt[9]  = mk(31, 0, 31, 1, 0, 0, 3, 0, 0, 0, 0,      1, 0,     1, 0);
    vt[10] = mk(31, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 0,     0, 7);

    idle_inputs();
    in_rst_n = 0;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1;
    step();

    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      in_d_valid = 1; in_d_src1 = vt[i].s1; in_d_src2 = vt[i].s2; in_d_dst = vt[i].dst;
      in_d_dst_en = vt[i].dst_en; in_d_use_imm = vt[i].use_imm; in_d_imm = vt[i].imm;
      in_d_rob_index = vt[i].tag; in_c_valid = vt[i].cv; in_c_wr_en = vt[i].cv;
      in_c_reg = vt[i].creg; in_c_value = vt[i].cval; in_c_rob_index = vt[i].ctag;
      step();
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("tbl%0d_s1v", i), 64'(out_src1_valid), 64'(vt[i].e1v));
      chk($sformatf("tbl%0d_s1d", i), vt[i].e1v ? out_src1_value : 64'(out_src1_rob_index), vt[i].e1d);
      chk($sformatf("tbl%0d_s2v", i), 64'(out_src2_valid), 64'(vt[i].e2v));
      chk($sformatf("tbl%0d_s2d", i), vt[i].e2v ? out_src2_value : 64'(out_src2_rob_index), vt[i].e2d);
    end

    // Rename x5 and flags to tag 2, then commit both in the cycle that reads them.
    idle_inputs();
    in_d_valid = 1; in_d_dst = 5; in_d_dst_en = 1; in_d_set_nzcv = 1; in_d_rob_index = 2;
    step();
    idle_inputs();
    in_d_valid = 1; in_d_src1 = 5;
    in_c_valid = 1; in_c_wr_en = 1; in_c_reg = 5; in_c_value = 64'h55; in_c_rob_index = 2;
    in_c_set_nzcv = 1; in_c_nzcv = 4'hA;
    step();
    chk("byp_s1_valid", 64'(out_src1_valid), 64'(BYP));
    chk("byp_s1_data", BYP ? out_src1_value : 64'(out_src1_rob_index), BYP ? 64'h55 : 64'd2);
    chk("byp_nzcv", BYP ? 64'(out_nzcv) : 64'(out_nzcv_rob_index), BYP ? 64'hA : 64'd2);

    // Flush drops the dispatch but still applies the commit to x7.
    idle_inputs();
    in_flush = 1; in_d_valid = 1; in_d_dst = 6; in_d_dst_en = 1; in_d_rob_index = 9;
    in_c_valid = 1; in_c_wr_en = 1; in_c_reg = 7; in_c_value = 64'h77; in_c_rob_index = 0;
    step();
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    idle_inputs();
    in_d_valid = 1; in_d_src1 = 6; in_d_src2 = 7;
    step();
    chk("flush_x6", {63'(0), out_src1_valid} | (out_src1_value << 1), 64'd1);
    chk("flush_x7", out_src2_value, 64'h77);
    idle_inputs();
    in_d_valid = 1; in_d_src1 = 5;
    step();
    chk("flush_x5", out_src1_value, 64'h55);
    chk("flush_nzcv", {59'(0), out_nzcv_valid, out_nzcv}, 64'h1A);

    // Back-pressure: one result held for three cycles, then one per cycle.
    idle_inputs();
    in_d_valid = 1; in_d_use_imm = 1; in_d_imm = 16'h100;
    step();
    for (int k = 1; k <= 3; k++) begin
      in_rob_ready = 0; in_d_imm = 16'(16'h100 + k);
      step();
      chk($sformatf("stall%0d_ready", k), 64'(out_d_ready), 64'(0));
      chk($sformatf("stall%0d_hold", k), out_src2_value, 64'h100);
    end
    for (int k = 4; k <= 5; k++) begin
      in_rob_ready = 1; in_d_imm = 16'(16'h100 + k);
      step();
      chk($sformatf("release%0d", k), out_src2_value, 64'(16'h100 + k));
    end

    // Reset while stalled discards the held result.
    in_rob_ready = 0; in_d_imm = 16'h1FF;
    step();
    #2;
    in_rst_n = 0;
    model_reset();
    #1;
    compare_all();
    @(negedge in_clk);
    in_rst_n = 1;
    idle_inputs();
    step();

    for (int n = 0; n < 500; n++) begin
      logic [4:0] cr;
      idle_inputs();
      in_d_valid     = ($urandom_range(3) != 0);
      in_d_src1      = ($urandom_range(7) == 0) ? 5'(ZR) : 5'($urandom_range(7));
      in_d_src2      = ($urandom_range(7) == 0) ? 5'(ZR) : 5'($urandom_range(7));
      in_d_dst       = ($urandom_range(7) == 0) ? 5'(ZR) : 5'($urandom_range(7));
      in_d_dst_en    = $urandom_range(1) == 1;
      in_d_set_nzcv  = $urandom_range(3) == 0;
      in_d_use_imm   = $urandom_range(3) == 0;
      in_d_imm       = 16'($urandom);
      in_d_rob_index = 4'($urandom);
      cr             = ($urandom_range(7) == 0) ? 5'(ZR) : 5'($urandom_range(7));
      in_c_valid     = $urandom_range(1) == 1;
      in_c_wr_en     = $urandom_range(3) != 0;
      in_c_reg       = cr;
      in_c_value     = {32'($urandom), 32'($urandom)};
      in_c_set_nzcv  = $urandom_range(3) == 0;
      in_c_nzcv      = 4'($urandom);
      if ($urandom_range(1) == 1) in_c_rob_index = in_c_set_nzcv ? mf_tag : m_tag[cr];
      else in_c_rob_index = 4'($urandom);
      in_flush       = $urandom_range(31) == 0;
      in_rob_ready   = $urandom_range(3) != 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
